// File: rtl/db_mv_fetch_pkg.sv
// Shared constants and encodings for the deblocking MV fetch sequencer.
package db_mv_fetch_pkg;

  localparam int unsigned FMV_WIDTH  = 10;
  localparam int unsigned MV_WIDTH   = 2 * FMV_WIDTH;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned BLK_NUM    = 8;
  localparam int unsigned TOP_BASE   = 64;
  localparam int unsigned LEFT_BASE  = 72;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISS_C,
    S_ISS_L,
    S_ISS_T,
    S_CAPT,
    S_OUT
  } state_e;

  typedef enum logic [1:0] {
    SLOT_CUR,
    SLOT_LEFT,
    SLOT_TOP,
    SLOT_NONE
  } slot_e;

endpackage

// File: rtl/db_mv_fetch_addr_gen.sv
// MV RAM address generator: maps (block x/y, read slot, LCU availability)
// to a RAM address and a read-enable that is dropped for missing LCU neighbours.
module db_mv_addr_gen
  import db_mv_fetch_pkg::*;
(
  input  logic [2:0]            x_i,
  input  logic [2:0]            y_i,
  input  slot_e                 slot_i,
  input  logic                  left_avail_i,
  input  logic                  top_avail_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  rd_en_o
);

  always_comb begin
    addr_o  = '0;
    rd_en_o = 1'b0;
    case (slot_i)
      SLOT_CUR: begin
        addr_o  = ADDR_WIDTH'({y_i, x_i});
        rd_en_o = 1'b1;
      end
      SLOT_LEFT: begin
        if (x_i != 3'd0) begin
          addr_o  = ADDR_WIDTH'({y_i, x_i - 3'd1});
          rd_en_o = 1'b1;
        end else begin
          addr_o  = ADDR_WIDTH'(LEFT_BASE + 32'(y_i));
          rd_en_o = left_avail_i;
        end
      end
      SLOT_TOP: begin
        if (y_i != 3'd0) begin
          addr_o  = ADDR_WIDTH'({y_i - 3'd1, x_i});
          rd_en_o = 1'b1;
        end else begin
          addr_o  = ADDR_WIDTH'(TOP_BASE + 32'(x_i));
          rd_en_o = top_avail_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/db_mv_fetch.sv
// Read-side sequencer for the deblocking MV RAM: walks the 64 8x8 blocks of an
// LCU and hands (cur, left, top) MV triples to the boundary-strength stage.
module db_mv_fetch
  import db_mv_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  lcu_left_avail_i,
  input  logic                  lcu_top_avail_i,
  output logic                  cen_o,
  output logic                  ren_o,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic [MV_WIDTH-1:0]   data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [2:0]            blk_x_o,
  output logic [2:0]            blk_y_o,
  output logic [MV_WIDTH-1:0]   mv_cur_o,
  output logic [MV_WIDTH-1:0]   mv_left_o,
  output logic [MV_WIDTH-1:0]   mv_top_o,
  output logic                  left_avail_o,
  output logic                  top_avail_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e state_q, state_d;
  slot_e  slot;

  logic [2:0]          x_q, y_q;
  logic                lcu_left_q, lcu_top_q;
  logic [MV_WIDTH-1:0] cur_q, left_q, top_q;
  logic                left_av_q, top_av_q;
  logic                busy_q, done_q;
  logic                rd_en, rd_en_q;
  logic                hs, last_blk;

  assign hs       = (state_q == S_OUT) && ready_i;
  assign last_blk = (x_q == 3'd7) && (y_q == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_ISS_C;
      S_ISS_C: state_d = S_ISS_L;
      S_ISS_L: state_d = S_ISS_T;
      S_ISS_T: state_d = S_CAPT;
      S_CAPT:  state_d = S_OUT;
      S_OUT:   if (ready_i) state_d = last_blk ? S_IDLE : S_ISS_C;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    slot    = SLOT_NONE;
    ren_o   = 1'b1;
    valid_o = 1'b0;
    case (state_q)
      S_ISS_C: slot = SLOT_CUR;
      S_ISS_L: begin slot = SLOT_LEFT; ren_o = 1'b0; end
      S_ISS_T: begin slot = SLOT_TOP;  ren_o = 1'b0; end
      S_CAPT:  ren_o = 1'b0;
      S_OUT:   valid_o = 1'b1;
      default: ;
    endcase
  end

  db_mv_addr_gen u_addr_gen (
    .x_i          (x_q),
    .y_i          (y_q),
    .slot_i       (slot),
    .left_avail_i (lcu_left_q),
    .top_avail_i  (lcu_top_q),
    .addr_o       (addr_o),
    .rd_en_o      (rd_en)
  );

  assign cen_o = ~rd_en;
  assign wen_o = 1'b1;

  // rd_en_q remembers whether the read feeding this cycle's capture was issued;
  // a suppressed read yields a zero MV and a cleared availability flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      lcu_left_q <= 1'b0;
      lcu_top_q  <= 1'b0;
      cur_q      <= '0;
      left_q     <= '0;
      top_q      <= '0;
      left_av_q  <= 1'b0;
      top_av_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      rd_en_q <= rd_en;
      done_q  <= hs && last_blk;
      if (state_q == S_IDLE && start_i) begin
        lcu_left_q <= lcu_left_avail_i;
        lcu_top_q  <= lcu_top_avail_i;
        x_q        <= '0;
        y_q        <= '0;
        busy_q     <= 1'b1;
      end
      if (hs) begin
        if (last_blk) begin
          busy_q <= 1'b0;
        end else begin
          x_q <= x_q + 3'd1;
          if (x_q == 3'd7) y_q <= y_q + 3'd1;
        end
      end
      case (state_q)
        S_ISS_L: cur_q <= data_i;
        S_ISS_T: begin
          left_q    <= rd_en_q ? data_i : '0;
          left_av_q <= rd_en_q;
        end
        S_CAPT: begin
          top_q    <= rd_en_q ? data_i : '0;
          top_av_q <= rd_en_q;
        end
        default: ;
      endcase
    end
  end

  assign blk_x_o      = x_q;
  assign blk_y_o      = y_q;
  assign mv_cur_o     = cur_q;
  assign mv_left_o    = left_q;
  assign mv_top_o     = top_q;
  assign left_avail_o = left_av_q;
  assign top_avail_o  = top_av_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_db_mv_fetch.sv
// Randomised self-checking bench for db_mv_fetch with a behavioural RAM and
// a per-block timeline model of the expected RAM port and output behaviour.
module tb_db_mv_fetch;

  logic        clk = 1'b0;
  logic        rst, start, left_av, top_av, ready;
  logic        cen_o, ren_o, wen_o, valid_o;
  logic [6:0]  addr_o;
  logic [19:0] data_i;
  logic [2:0]  blk_x_o, blk_y_o;
  logic [19:0] mv_cur_o, mv_left_o, mv_top_o;
  logic        left_avail_o, top_avail_o, busy_o, done_o;

  always #5 clk = ~clk;

  db_mv_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .lcu_left_avail_i (left_av),
    .lcu_top_avail_i  (top_av),
    .cen_o            (cen_o),
    .ren_o            (ren_o),
    .wen_o            (wen_o),
    .addr_o           (addr_o),
    .data_i           (data_i),
    .valid_o          (valid_o),
    .ready_i          (ready),
    .blk_x_o          (blk_x_o),
    .blk_y_o          (blk_y_o),
    .mv_cur_o         (mv_cur_o),
    .mv_left_o        (mv_left_o),
    .mv_top_o         (mv_top_o),
    .left_avail_o     (left_avail_o),
    .top_avail_o      (top_avail_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  // RAM: registered read; unread or output-disabled cycles present garbage.
  logic [19:0] mem [0:127];
  logic [19:0] rdata_q, junk_q;
  always @(posedge clk) begin
    junk_q  <= 20'($urandom);
    rdata_q <= (cen_o == 1'b0) ? mem[addr_o] : 20'($urandom);
  end
  assign data_i = ren_o ? junk_q : rdata_q;

  int nchk = 0, nerr = 0, cyc = 0;
  bit run = 0, lit_mode = 0, full_rate = 0;

  // Model state
  bit m_act = 0, m_done = 0, m_rst = 1, m_lav = 0, m_tav = 0;
  int ph = 0, bx = 0, by = 0, hs_cnt = 0, start_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d blk(%0d,%0d) ph %0d: got %0h expected %0h",
               name, cyc, bx, by, ph, act, exp);
    end
  endtask

  function automatic int a_cur(int x, int y);  return y * 8 + x; endfunction
  function automatic int a_left(int x, int y); return (x > 0) ? y * 8 + x - 1 : 72 + y; endfunction
  function automatic int a_top(int x, int y);  return (y > 0) ? (y - 1) * 8 + x : 64 + x; endfunction

  always @(negedge clk) begin
    cyc++;
    if (run) begin
      chk("wen", 32'(wen_o), 32'd1);
      chk("addr_range", 32'(addr_o <= 7'd79), 32'd1);
      chk("busy", 32'(busy_o), 32'(m_act));
      chk("done", 32'(done_o), 32'(m_done));
      chk("valid", 32'(valid_o), 32'(m_act && ph >= 5));
      if (!m_act) begin
        chk("idle_cen", 32'(cen_o), 32'd1);
        chk("idle_ren", 32'(ren_o), 32'd1);
        if (m_rst) begin
          chk("rst_addr", 32'(addr_o), 32'd0);
          chk("rst_cur", 32'(mv_cur_o), 32'd0);
          chk("rst_left", 32'(mv_left_o), 32'd0);
          chk("rst_top", 32'(mv_top_o), 32'd0);
          chk("rst_lav", 32'(left_avail_o), 32'd0);
          chk("rst_tav", 32'(top_avail_o), 32'd0);
          chk("rst_bx", 32'(blk_x_o), 32'd0);
          chk("rst_by", 32'(blk_y_o), 32'd0);
        end
      end else begin
        case (ph)
          1: begin
            chk("c_cen", 32'(cen_o), 32'd0);
            chk("c_ren", 32'(ren_o), 32'd1);
            chk("c_addr", 32'(addr_o), 32'(a_cur(bx, by)));
          end
          2: begin
            chk("l_cen", 32'(cen_o), 32'(bx == 0 && !m_lav));
            chk("l_ren", 32'(ren_o), 32'd0);
            chk("l_addr", 32'(addr_o), 32'(a_left(bx, by)));
          end
          3: begin
            chk("t_cen", 32'(cen_o), 32'(by == 0 && !m_tav));
            chk("t_ren", 32'(ren_o), 32'd0);
            chk("t_addr", 32'(addr_o), 32'(a_top(bx, by)));
          end
          4: begin
            chk("capt_cen", 32'(cen_o), 32'd1);
            chk("capt_ren", 32'(ren_o), 32'd0);
          end
          default: begin
            chk("out_cen", 32'(cen_o), 32'd1);
            chk("out_ren", 32'(ren_o), 32'd1);
            chk("blk_x", 32'(blk_x_o), 32'(bx));
            chk("blk_y", 32'(blk_y_o), 32'(by));
            chk("mv_cur", 32'(mv_cur_o), 32'(mem[a_cur(bx, by)]));
            chk("mv_left", 32'(mv_left_o),
                (bx > 0 || m_lav) ? 32'(mem[a_left(bx, by)]) : 32'd0);
            chk("mv_top", 32'(mv_top_o),
                (by > 0 || m_tav) ? 32'(mem[a_top(bx, by)]) : 32'd0);
            chk("left_avail", 32'(left_avail_o), 32'(bx > 0 || m_lav));
            chk("top_avail", 32'(top_avail_o), 32'(by > 0 || m_tav));
            if (lit_mode && ph == 5) begin
              if (bx == 0 && by == 0 && m_lav && m_tav) begin
                chk("lit00_cur", 32'(mv_cur_o), 32'd0);
                chk("lit00_left", 32'(mv_left_o), 32'd72);
                chk("lit00_top", 32'(mv_top_o), 32'd64);
              end
              if (bx == 3 && by == 2) begin
                chk("lit32_cur", 32'(mv_cur_o), 32'd19);
                chk("lit32_left", 32'(mv_left_o), 32'd18);
                chk("lit32_top", 32'(mv_top_o), 32'd11);
              end
              if (bx == 1 && by == 5) chk("lit15_left", 32'(mv_left_o), 32'd40);
              if (bx == 0 && by == 5 && !m_lav) begin
                chk("lit05_left", 32'(mv_left_o), 32'd0);
                chk("lit05_lav", 32'(left_avail_o), 32'd0);
              end
            end
          end
        endcase
      end
      if (m_done && full_rate) begin
        chk("lcu_cycles", 32'(cyc - start_cyc), 32'd321);
        chk("handshakes", 32'(hs_cnt), 32'd64);
      end

      m_done = 0;
      if (rst) begin
        m_act = 0;
        m_rst = 1;
      end else if (!m_act) begin
        if (start) begin
          m_act = 1; ph = 1; bx = 0; by = 0; hs_cnt = 0;
          m_lav = left_av; m_tav = top_av; m_rst = 0; start_cyc = cyc;
        end
      end else if (ph >= 5) begin
        if (ready) begin
          hs_cnt++;
          if (bx == 7 && by == 7) begin
            m_act = 0; m_done = 1;
          end else begin
            ph = 1;
            if (bx == 7) begin bx = 0; by++; end else bx++;
          end
        end
      end else begin
        ph++;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 4000) begin
      @(negedge clk); n++;
      if (done_o === 1'b1) seen = 1;
      else if (rnd) begin @(posedge clk); #1 ready = 1'($urandom_range(0, 1)); end
    end
    if (!seen) begin
      nchk++; nerr++;
      $display("FAIL done_timeout: got no done_o in %0d cycles, required one", n);
    end
  endtask

  task automatic wait_blk(input int x, input int y);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(valid_o === 1'b1 && 32'(blk_x_o) == x && 32'(blk_y_o) == y) && n < 2000);
    if (n >= 2000) begin
      nchk++; nerr++;
      $display("FAIL wait_blk: got no valid block (%0d,%0d), required one", x, y);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 20'(i);
    rst = 1; start = 0; ready = 1; left_av = 1; top_av = 1;
    lit_mode = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0; run = 1;
    repeat (2) @(posedge clk);

    // Full LCU at full rate, with a stray start while busy.
    full_rate = 1;
    pulse_start();
    repeat (40) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(0);

    // Left LCU missing.
    left_av = 0;
    pulse_start();
    wait_done(0);

    // Ten-cycle stall on block (7,0).
    full_rate = 0; left_av = 1;
    pulse_start();
    wait_blk(6, 0);
    @(posedge clk); #1 ready = 0;
    wait_blk(7, 0);
    repeat (10) @(posedge clk);
    #1 ready = 1;
    wait_done(0);

    // Reset while block (4,4) is on the output, then a clean restart.
    pulse_start();
    wait_blk(3, 4);
    @(posedge clk); #1 ready = 0;
    wait_blk(4, 4);
    @(posedge clk); #1 rst = 1; ready = 1;
    @(posedge clk); #1 rst = 0;
    repeat (5) @(posedge clk);
    full_rate = 1;
    pulse_start();
    wait_done(0);

    // Random RAM contents, availability and back-pressure.
    lit_mode = 0; full_rate = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 128; i++) mem[i] = 20'($urandom);
      left_av = 1'($urandom_range(0, 1));
      top_av  = 1'($urandom_range(0, 1));
      pulse_start();
      wait_done(1);
      @(posedge clk); #1 ready = 1;
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/db_mv_fetch.md
Name: db_mv_fetch

Overview:
- Read-side sequencer for the deblocking MV RAM: 128 x (2*FMV_WIDTH) words, active-low cen/ren/wen, 1-cycle registered read.
- Per 64x64 LCU, walks the 64 8x8 blocks in raster order. For each block it reads the current, left-neighbour and top-neighbour MVs.
- Presents each triple to the boundary-strength stage over a valid/ready handshake.
- Sits between the MV RAM port B and db_bs.

Parameters:
- FMV_WIDTH, 10, width of one MV component.
- MV_WIDTH, 2*FMV_WIDTH, RAM word width.
- ADDR_WIDTH, 7, RAM address width.
- BLK_NUM, 8, 8x8 blocks per LCU side.
- TOP_BASE, 64, address of top-neighbour row (64+x).
- LEFT_BASE, 72, address of left-neighbour column (72+y).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- start_i  in  1  one-cycle pulse, begin LCU.
- lcu_left_avail_i  in  1  left LCU exists (sampled at start).
- lcu_top_avail_i  in  1  top LCU exists (sampled at start).
- cen_o  out  1  RAM chip enable, low active.
- ren_o  out  1  RAM output enable, low active.
- wen_o  out  1  RAM write enable, low active (tied 1).
- addr_o  out  ADDR_WIDTH  RAM address.
- data_i  in  MV_WIDTH  RAM read data.
- valid_o  out  1  triple valid.
- ready_i  in  1  consumer accepts.
- blk_x_o  out  3  block column.
- blk_y_o  out  3  block row.
- mv_cur_o  out  MV_WIDTH  current-block MV.
- mv_left_o  out  MV_WIDTH  left-neighbour MV.
- mv_top_o  out  MV_WIDTH  top-neighbour MV.
- left_avail_o  out  1  left MV valid.
- top_avail_o  out  1  top MV valid.
- busy_o  out  1  LCU in progress.
- done_o  out  1  one-cycle pulse after last handshake.

Behaviour:
- Reset values: cen_o=1, ren_o=1, wen_o=1, addr_o=0, valid_o=0, busy_o=0, done_o=0, MV outputs 0, avail flags 0, blk_x/y=0. FSM goes to IDLE.
- rst is honoured in any state. A mid-LCU reset aborts the LCU with no done_o.
- FSM states: IDLE, ISS_C, ISS_L, ISS_T, CAPT, OUT.
- IDLE: start_i -> ISS_C. Latch avail inputs; x=y=0; busy_o=1.
- start_i outside IDLE is ignored.
- ISS_C:
  - addr = y*8+x, cen_o=0.
- ISS_L:
  - Capture data_i -> cur.
  - Left address: x>0 -> y*8+x-1; x=0 -> LEFT_BASE+y.
  - If x=0 and left LCU unavailable: cen_o=1 for this slot, left forced to 0, left_avail=0.
- ISS_T:
  - Capture left.
  - Top address: y>0 -> (y-1)*8+x; y=0 -> TOP_BASE+x.
  - Same unavailability rule using the top flag.
- CAPT: capture top; cen_o=1 -> OUT.
- Read cadence: RAM data for the address issued in cycle n is sampled at the end of cycle n+1.
  - ren_o=0 in every cycle where a capture happens; otherwise ren_o=1.
  - Captures that follow a suppressed read ignore data_i (it may be x/z).
- OUT: valid_o=1 with all fields stable until ready_i.
  - On handshake: advance x, wrapping 7->0 with y+1.
  - After block (7,7): done_o=1 for one cycle, busy_o=0 -> IDLE.
  - Otherwise -> ISS_C.
- Latency:
  - valid_o rises 4 cycles after ISS_C entry.
  - With ready_i held 1 the rate is 5 cycles per block, so an LCU takes 320 cycles plus 1 (start).
- ready_i asserted before valid_o has no effect.
- valid_o never drops without a handshake.
- No RAM write is ever issued: wen_o is constant 1.

Decomposition:
- Shared package (enc_defines): FMV_WIDTH, TOP_BASE, LEFT_BASE, FSM state encodings.
- One natural sub-module, db_mv_addr_gen: combinational (x, y, slot, avail) -> (addr, read_enable).
- The FSM and capture registers stay in db_mv_fetch.

Test Plan:
1. RAM preloaded with addr[i]=i, both avail=1, ready_i=1, start:
   - Block (0,0) gives cur=0, left=72, top=64.
   - Block (3,2) gives cur=19, left=18, top=11.
   - 64 handshakes, done_o at cycle 321.
2. left_avail=0:
   - Block (0,5): cen_o stays 1 in the ISS_L slot, mv_left_o=0, left_avail_o=0.
   - Block (1,5): left=40.
3. ready_i low for 10 cycles at block (7,0):
   - valid_o held and fields stable.
   - No RAM access during the stall.
   - Resume yields block (0,1).
4. rst asserted mid-LCU at block (4,4):
   - All outputs at reset values the next cycle, no done_o.
   - A following start restarts at (0,0).
5. start_i pulsed while busy_o=1 -> ignored; sequence and count unchanged.
6. Protocol check over the full LCU:
   - wen_o==1 always.
   - ren_o==0 exactly in capture cycles.
   - addr_o within 0..79.
